sd_sched: RTL

- Two-requester sector-read scheduler in front of the SPI SD controller.
- Arbitrates round-robin between requester 0 (CPU disk port) and requester 1 (boot/DMA loader).
- Expands a multi-sector request (start LBA, count) into single-sector SD read commands, retries failed sectors, and forwards read bytes tagged with requester and sector index.

---
 rtl/sd_sched_if.sv | 42 ++++
 rtl/sd_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sd_sched_if.sv
// Signal bundle between the sector-read scheduler, its two requesters and the SPI SD controller.
// slave is the scheduler's view; master is the environment (requesters + SD controller).
interface sd_sched_if;
  logic [1:0]  req;
  logic [31:0] lba0;
  logic [31:0] lba1;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [1:0]  fail;
  logic [3:0]  errcode;
  logic        sd_command;
  logic        sd_rw;
  logic [31:0] sd_lba;
  logic        sd_busy;
  logic        sd_done;
  logic [3:0]  sd_error;
  logic [8:0]  sd_a;
  logic [7:0]  sd_o;
  logic        sd_w;
  logic [8:0]  out_a;
  logic [7:0]  out_o;
  logic [1:0]  out_w;
  logic [7:0]  out_sec;

  modport slave (
    input  req, lba0, lba1, cnt0, cnt1,
    input  sd_busy, sd_done, sd_error, sd_a, sd_o, sd_w,
    output grant, done, fail, errcode,
    output sd_command, sd_rw, sd_lba,
    output out_a, out_o, out_w, out_sec
  );

  modport master (
    output req, lba0, lba1, cnt0, cnt1,
    output sd_busy, sd_done, sd_error, sd_a, sd_o, sd_w,
    input  grant, done, fail, errcode,
    input  sd_command, sd_rw, sd_lba,
    input  out_a, out_o, out_w, out_sec
  );
endinterface

// File: rtl/sd_sched.sv
// Round-robin two-requester scheduler that splits multi-sector reads into single-sector
// SD commands, retries failed sectors and forwards the read bytes to the granted requester.
module sd_sched #(
  parameter int RETRIES = 2,
  parameter int TMO     = 16
) (
  input  logic      clock,
  input  logic      reset,
  sd_sched_if.slave bus
);
  localparam int TW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam int MW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAITBSY, XFER, NEXT, END} state_t;

  state_t         state_reg, state_next;
  logic           g_reg, g_next;
  logic           last_reg, last_next;
  logic [31:0]    cur_lba_reg, cur_lba_next;
  logic [7:0]     remain_reg, remain_next;
  logic [7:0]     sec_reg, sec_next;
  logic [TW-1:0]  tries_reg, tries_next;
  logic [MW-1:0]  timer_reg, timer_next;
  logic [1:0]     grant_reg, grant_next;
  logic [1:0]     done_reg, done_next;
  logic [1:0]     fail_reg, fail_next;
  logic [3:0]     errcode_reg, errcode_next;
  logic           cmd_reg, cmd_next;
  logic [31:0]    sd_lba_reg, sd_lba_next;

  logic [1:0]     req_eff;
  logic           err;
  logic [3:0]     err_code;
  logic           xfer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      g_reg       <= 1'b0;
      last_reg    <= 1'b1;
      cur_lba_reg <= '0;
      remain_reg  <= '0;
      sec_reg     <= '0;
      tries_reg   <= '0;
      timer_reg   <= '0;
      grant_reg   <= '0;
      done_reg    <= '0;
      fail_reg    <= '0;
      errcode_reg <= '0;
      cmd_reg     <= 1'b0;
      sd_lba_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      g_reg       <= g_next;
      last_reg    <= last_next;
      cur_lba_reg <= cur_lba_next;
      remain_reg  <= remain_next;
      sec_reg     <= sec_next;
      tries_reg   <= tries_next;
      timer_reg   <= timer_next;
      grant_reg   <= grant_next;
      done_reg    <= done_next;
      fail_reg    <= fail_next;
      errcode_reg <= errcode_next;
      cmd_reg     <= cmd_next;
      sd_lba_reg  <= sd_lba_next;
    end
  end

  // A requester still seeing its own done/fail pulse has not had a chance to drop req yet.
  assign req_eff = bus.req & ~(done_reg | fail_reg);

  always_comb begin
    state_next   = state_reg;
    g_next       = g_reg;
    last_next    = last_reg;
    cur_lba_next = cur_lba_reg;
    remain_next  = remain_reg;
    sec_next     = sec_reg;
    tries_next   = tries_reg;
    timer_next   = timer_reg;
    grant_next   = grant_reg;
    done_next    = 2'b00;
    fail_next    = 2'b00;
    errcode_next = errcode_reg;
    cmd_next     = 1'b0;
    sd_lba_next  = sd_lba_reg;
    err          = 1'b0;
    err_code     = 4'h0;

    case (state_reg)
      IDLE: begin
        if (req_eff != 2'b00) begin
          g_next       = (req_eff == 2'b11) ? ~last_reg : req_eff[1];
          grant_next   = {g_next, ~g_next};
          errcode_next = 4'h0;
          state_next   = GRANT;
        end
      end
      GRANT: begin
        cur_lba_next = g_reg ? bus.lba1 : bus.lba0;
        remain_next  = g_reg ? bus.cnt1 : bus.cnt0;
        sec_next     = 8'd0;
        tries_next   = TW'(RETRIES);
        last_next    = g_reg;
        state_next   = (remain_next == 8'd0) ? END : ISSUE;
      end
      ISSUE: begin
        // The SD controller may still be finishing a sequence started before a reset.
        if (!bus.sd_busy) begin
          cmd_next    = 1'b1;
          sd_lba_next = cur_lba_reg;
          timer_next  = MW'(TMO);
          state_next  = WAITBSY;
        end
      end
      WAITBSY: begin
        if (bus.sd_busy) begin
          state_next = XFER;
        end else if (timer_reg == '0) begin
          err      = 1'b1;
          err_code = 4'hF;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      XFER: begin
        if (bus.sd_done) begin
          state_next = NEXT;
        end else if (!bus.sd_busy) begin
          err      = 1'b1;
          err_code = bus.sd_error;
        end
      end
      NEXT: begin
        cur_lba_next = cur_lba_reg + 32'd1;
        remain_next  = remain_reg - 8'd1;
        sec_next     = sec_reg + 8'd1;
        tries_next   = TW'(RETRIES);
        state_next   = (remain_reg == 8'd1) ? END : ISSUE;
      end
      END: begin
        done_next  = grant_reg;
        grant_next = 2'b00;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (err) begin
      if (tries_reg != '0) begin
        tries_next = tries_reg - 1'b1;
        state_next = ISSUE;
      end else begin
        errcode_next = err_code;
        fail_next    = grant_reg;
        grant_next   = 2'b00;
        state_next   = IDLE;
      end
    end
  end

  assign xfer = (state_reg == XFER);

  assign bus.grant      = grant_reg;
  assign bus.done       = done_reg;
  assign bus.fail       = fail_reg;
  assign bus.errcode    = errcode_reg;
  assign bus.sd_command = cmd_reg;
  assign bus.sd_rw      = 1'b0;
  assign bus.sd_lba     = sd_lba_reg;
  assign bus.out_sec    = sec_reg;
  assign bus.out_a      = xfer ? bus.sd_a : 9'd0;
  assign bus.out_o      = xfer ? bus.sd_o : 8'd0;
  assign bus.out_w      = xfer ? ({2{bus.sd_w}} & grant_reg) : 2'b00;
endmodule
